// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store on a 64-bit doubleword array,
// answered after a fixed programmable latency over a valid/ready response channel.
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] data_q;
   logic        err_q;

   logic [63:0] mem [DEPTH];

   logic          accept;
   logic          addr_err;
   logic [AW-1:0] idx;

   assign accept   = req_valid && req_ready;
   assign idx      = req_addr[3 +: AW];
   assign addr_err = (req_addr[2:0] != 3'b000) || (req_addr >= (64'(DEPTH) << 3));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? StResp : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         data_q  <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            err_q  <= addr_err;
            // Load data is captured at accept so a store later in time cannot alter it.
            data_q <= (!req_write && !addr_err) ? mem[idx] : 64'd0;
         end
      end
   end

   // Array has no reset; a store commits at its own accept edge.
   always_ff @(posedge clk) begin
      if (accept && req_write && !addr_err) begin
         mem[idx] <= req_wdata;
      end
   end

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rsp_valid ? data_q : 64'd0;
   assign rsp_err   = rsp_valid && err_q;

endmodule
